// File: rtl/sm83_pkg.sv
// Shared SM83 core types and the opcode immediate-length table.
package sm83_pkg;

    typedef enum logic [1:0] {
        S_OPC,
        S_CB,
        S_IMM_LO,
        S_IMM_HI
    } fetch_state_t;

    localparam logic [7:0] OPC_CB_PREFIX = 8'hCB;

    // Number of immediate bytes following a non-prefixed opcode.
    function automatic logic [1:0] imm_len(input logic [7:0] opc);
        case (opc)
            8'h01, 8'h11, 8'h21, 8'h31,
            8'h08, 8'hC2, 8'hC3, 8'hC4,
            8'hCA, 8'hCC, 8'hCD, 8'hD2,
            8'hD4, 8'hDA, 8'hDC, 8'hEA,
            8'hFA:
                imm_len = 2'd2;
            8'h06, 8'h0E, 8'h10, 8'h16,
            8'h18, 8'h1E, 8'h20, 8'h26,
            8'h28, 8'h2E, 8'h30, 8'h36,
            8'h38, 8'h3E, 8'hC6, 8'hCE,
            8'hD6, 8'hDE, 8'hE0, 8'hE6,
            8'hE8, 8'hEE, 8'hF0, 8'hF6,
            8'hF8, 8'hFE:
                imm_len = 2'd1;
            default:
                imm_len = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sm83_fetch.sv
// SM83 instruction fetch stage: byte-serial fetch at PC and
// assembly of opcode, CB-prefix opcode and immediates.
module sm83_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_cycle,
    input  logic        execute_cycle,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [15:0] jump_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] pc,
    output logic [7:0]  ir,
    output logic        cb,
    output logic [15:0] imm,
    output logic        instr_valid
);
    import sm83_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [7:0]  opc_q;
    logic [7:0]  lo_q;
    logic        two_q;
    logic        done;
    logic        jump;
    logic [7:0]  ir_d;
    logic        cb_d;
    logic [15:0] imm_d;

    assign jump     = execute_cycle & jump_valid;
    assign mem_rd   = fetch_cycle & ~stall;
    assign mem_addr = pc;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        ir_d    = opc_q;
        cb_d    = 1'b0;
        imm_d   = 16'h0000;
        unique case (state_q)
            S_OPC: begin
                ir_d = mem_rdata;
                if (mem_rdata == OPC_CB_PREFIX)
                    state_d = S_CB;
                else if (imm_len(mem_rdata) == 2'd0)
                    done = 1'b1;
                else
                    state_d = S_IMM_LO;
            end
            S_CB: begin
                ir_d = mem_rdata;
                cb_d = 1'b1;
                done = 1'b1;
            end
            S_IMM_LO: begin
                imm_d = {8'h00, mem_rdata};
                if (two_q)
                    state_d = S_IMM_HI;
                else
                    done = 1'b1;
            end
            S_IMM_HI: begin
                imm_d = {mem_rdata, lo_q};
                done  = 1'b1;
            end
            default: ;
        endcase
        if (done)
            state_d = S_OPC;
    end

    // A jump overrides any coincident fetch and drops its byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_OPC;
        else if (jump)
            state_q <= S_OPC;
        else if (mem_rd)
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            opc_q       <= 8'h00;
            lo_q        <= 8'h00;
            two_q       <= 1'b0;
            ir          <= 8'h00;
            cb          <= 1'b0;
            imm         <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (jump) begin
                pc    <= jump_addr;
                opc_q <= 8'h00;
                lo_q  <= 8'h00;
                two_q <= 1'b0;
            end else if (mem_rd) begin
                pc <= pc + 16'd1;
                if (state_q == S_OPC) begin
                    opc_q <= mem_rdata;
                    two_q <= (imm_len(mem_rdata) == 2'd2);
                end
                if (state_q == S_IMM_LO)
                    lo_q <= mem_rdata;
                if (done) begin
                    ir          <= ir_d;
                    cb          <= cb_d;
                    imm         <= imm_d;
                    instr_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_fetch.sv
// Self-checking bench for sm83_fetch: memory image, instruction-level
// reference model compared every cycle, plus directed literal checks.
module tb_sm83_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_cycle;
    logic        execute_cycle;
    logic        stall;
    logic        jump_valid;
    logic [15:0] jump_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [15:0] pc;
    logic [7:0]  ir;
    logic        cb;
    logic [15:0] imm;
    logic        instr_valid;

    sm83_fetch #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_cycle  (fetch_cycle),
        .execute_cycle(execute_cycle),
        .stall        (stall),
        .jump_valid   (jump_valid),
        .jump_addr    (jump_addr),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .pc           (pc),
        .ir           (ir),
        .cb           (cb),
        .imm          (imm),
        .instr_valid  (instr_valid)
    );

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: instruction length table and byte queue.
    logic [1:0]  len_tab [256];
    logic [7:0]  two_l [17] = '{
        8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2,
        8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2,
        8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA};
    logic [7:0]  one_l [26] = '{
        8'h06, 8'h0E, 8'h10, 8'h16, 8'h18, 8'h1E,
        8'h20, 8'h26, 8'h28, 8'h2E, 8'h30, 8'h36,
        8'h38, 8'h3E, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
        8'hE0, 8'hE6, 8'hE8, 8'hEE, 8'hF0, 8'hF6,
        8'hF8, 8'hFE};

    logic [15:0] m_pc;
    logic [7:0]  m_ir;
    logic        m_cb;
    logic [15:0] m_imm;
    logic        m_valid;
    logic [7:0]  q [$];

    task automatic model_step();
        int need;
        if (!rst_n) begin
            m_pc    = RST_PC;
            m_ir    = 8'h00;
            m_cb    = 1'b0;
            m_imm   = 16'h0000;
            m_valid = 1'b0;
            q.delete();
        end else begin
            m_valid = 1'b0;
            if (execute_cycle && jump_valid) begin
                m_pc = jump_addr;
                q.delete();
            end else if (fetch_cycle && !stall) begin
                q.push_back(mem[m_pc]);
                m_pc = m_pc + 16'd1;
                if (q[0] == 8'hCB) need = 2;
                else need = 1 + int'(len_tab[q[0]]);
                if (q.size() == need) begin
                    m_valid = 1'b1;
                    m_cb    = (q[0] == 8'hCB);
                    m_ir    = m_cb ? q[1] : q[0];
                    if (m_cb || need == 1) m_imm = 16'h0000;
                    else if (need == 2) m_imm = {8'h00, q[1]};
                    else m_imm = {q[2], q[1]};
                    q.delete();
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pc", pc, m_pc);
            chk("cyc_addr", mem_addr, m_pc);
            chk("cyc_rd", mem_rd, fetch_cycle & ~stall);
            chk("cyc_valid", instr_valid, m_valid);
            chk("cyc_ir", ir, m_ir);
            chk("cyc_cb", cb, m_cb);
            chk("cyc_imm", imm, m_imm);
        end
    end

    task automatic step(input logic f, input logic e,
                        input logic s, input logic jv,
                        input logic [15:0] ja);
        fetch_cycle   = f;
        execute_cycle = e;
        stall         = s;
        jump_valid    = jv;
        jump_addr     = ja;
        @(posedge clk);
        #1;
        fetch_cycle   = 1'b0;
        execute_cycle = 1'b0;
        stall         = 1'b0;
        jump_valid    = 1'b0;
        jump_addr     = 16'h0000;
    endtask

    task automatic fetch();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) len_tab[i] = 2'd0;
        foreach (two_l[i]) len_tab[two_l[i]] = 2'd2;
        foreach (one_l[i]) len_tab[one_l[i]] = 2'd1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        fetch_cycle   = 1'b0;
        execute_cycle = 1'b0;
        stall         = 1'b0;
        jump_valid    = 1'b0;
        jump_addr     = 16'h0000;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_imm", imm, 16'h0000);
        do_reset();

        fetch();
        chk("nop_valid", instr_valid, 1'b1);
        chk("nop_ir", ir, 8'h00);
        chk("nop_pc", pc, 16'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("nop_pulse", instr_valid, 1'b0);

        mem[0] = 8'hC3; mem[1] = 8'h50; mem[2] = 8'h01;
        mem[3] = 8'hCB; mem[4] = 8'h37;
        mem[5] = 8'h3E; mem[6] = 8'h42;
        mem[7] = 8'h06; mem[8] = 8'h99;
        mem[9] = 8'h01; mem[10] = 8'h34; mem[11] = 8'h12;
        do_reset();

        fetch(); fetch();
        chk("jp_mid", instr_valid, 1'b0);
        fetch();
        chk("jp_valid", instr_valid, 1'b1);
        chk("jp_ir", ir, 8'hC3);
        chk("jp_imm", imm, 16'h0150);
        chk("jp_pc", pc, 16'h0003);

        fetch();
        chk("cb_mid", instr_valid, 1'b0);
        fetch();
        chk("cb_ir", ir, 8'h37);
        chk("cb_flag", cb, 1'b1);
        chk("cb_imm", imm, 16'h0000);
        fetch(); fetch();
        chk("ld_ir", ir, 8'h3E);
        chk("ld_cb", cb, 1'b0);
        chk("ld_imm", imm, 16'h0042);

        fetch();
        fetch_cycle = 1'b1;
        stall       = 1'b1;
        #1 chk("stall_rd", mem_rd, 1'b0);
        @(posedge clk); #1;
        fetch_cycle = 1'b0;
        stall       = 1'b0;
        chk("stall_pc", pc, 16'h0008);
        fetch();
        chk("stall_imm", imm, 16'h0099);
        chk("stall_pc2", pc, 16'h0009);

        fetch(); fetch();
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h8000);
        chk("jmp_ignored", pc, 16'h000B);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h8000);
        chk("jmp_pc", pc, 16'h8000);
        chk("jmp_novalid", instr_valid, 1'b0);
        fetch();
        chk("jmp_next", instr_valid, 1'b1);
        chk("jmp_next_pc", pc, 16'h8001);

        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h4000);
        chk("jmp_wins", pc, 16'h4000);
        chk("jmp_wins_v", instr_valid, 1'b0);

        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        mem[0] = 8'h3E; mem[1] = 8'h42;
        fetch();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_valid", instr_valid, 1'b1);

        fetch();
        #2 rst_n = 1'b0;
        #1 chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("midrst_stale", instr_valid, 1'b0);
        fetch(); fetch();
        chk("post_ir", ir, 8'h3E);
        chk("post_imm", imm, 16'h0042);
        chk("post_pc", pc, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
